// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - word serialiser and match-count sequencer for the run-length sequence detector
//
// Purpose:
//   Accepts parallel words over a valid/ready handshake and shifts them
//   MSB-first onto the detector w input, one bit per det_en cycle. Counts
//   detector z pulses with saturation and raises a sticky irq once the
//   count reaches cfg_thresh at a word boundary. Flushes the detector
//   (det_clr) at the start of every run.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   cfg_start, cfg_stop  arm a run (IDLE only) / abort from any state
//   cfg_thresh           match count that completes a run
//   in_valid, in_data    word source; in_ready accepts a word this cycle
//   det_w, det_en        serial bit and advance strobe to the detector
//   det_clr              one-cycle detector flush
//   det_z                detector output, meaningful while det_en=1
//   match_cnt            saturating match count for the current run
//   busy                 controller is not idle
//   irq, irq_clr         sticky run-complete flag and its clear
module seq_det_sched #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_w,
    output logic              det_en,
    output logic              det_clr,
    input  logic              det_z,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              busy,
    output logic              irq,
    input  logic              irq_clr
);

    localparam int BIT_W = $clog2(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WORD_W-1:0]  sr_q;
    logic [BIT_W-1:0]   bitcnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               in_ready_q;
    logic               det_en_q;
    logic               det_clr_q;
    logic               irq_q;

    // Count including the bit on the wire this cycle; holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (det_en_q && det_z && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            bitcnt_q   <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            det_en_q   <= 1'b0;
            det_clr_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else if (cfg_stop) begin
            // Abort wins over everything; the count of the aborted run is kept.
            state_q    <= S_IDLE;
            sr_q       <= '0;
            bitcnt_q   <= '0;
            in_ready_q <= 1'b0;
            det_en_q   <= 1'b0;
            det_clr_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        state_q   <= S_CLEAR;
                        det_clr_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    det_clr_q  <= 1'b0;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (in_valid && in_ready_q) begin
                        sr_q       <= in_data;
                        bitcnt_q   <= BIT_W'(WORD_W - 1);
                        in_ready_q <= 1'b0;
                        det_en_q   <= 1'b1;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    cnt_q <= cnt_d;
                    sr_q  <= {sr_q[WORD_W-2:0], 1'b0};
                    if (bitcnt_q == '0) begin
                        det_en_q <= 1'b0;
                        // Threshold compare includes the match on the last bit.
                        if (cnt_d >= cfg_thresh) begin
                            irq_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= S_WAIT;
                        end
                    end else begin
                        bitcnt_q <= bitcnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (irq_clr) begin
                        irq_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The shift register is zero outside SHIFT, so its MSB serves as det_w.
    assign det_w     = sr_q[WORD_W-1];
    assign det_en    = det_en_q;
    assign det_clr   = det_clr_q;
    assign in_ready  = in_ready_q;
    assign irq       = irq_q;
    assign match_cnt = cnt_q;
    assign busy      = (state_q != S_IDLE);

endmodule
